// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and default widths for the instruction fetch stage.
// FETCH_HALT_EN enables the halt opcode handling (S_HALT and the HALTED port).
package fetch_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int INSTR_W_DEF = 8;
  localparam int OPC_W_DEF   = 4;
  localparam logic [OPC_W_DEF-1:0] HALT_OPC_DEF = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, its program ROM and the execute stage.
// FETCH_HALT_EN adds the HALTED status line.
//
// Handshake: the fetch unit raises OUT_VALID with OPCODE/OPERAND/PC_OUT held
// stable; the instruction is transferred on a rising clock edge where
// OUT_VALID and OUT_READY are both 1. OUT_VALID never drops without a
// transfer except when a redirect (BR_VALID) or reset squashes the word.
interface instr_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int OPC_W   = OPC_W_DEF
)();

  logic                       EN;
  logic [ADDR_W-1:0]          MEM_ADDR;
  logic [INSTR_W-1:0]         MEM_DATA;
  logic                       BR_VALID;
  logic [ADDR_W-1:0]          BR_TARGET;
  logic                       OUT_VALID;
  logic                       OUT_READY;
  logic [OPC_W-1:0]           OPCODE;
  logic [INSTR_W-OPC_W-1:0]   OPERAND;
  logic [ADDR_W-1:0]          PC_OUT;
`ifdef FETCH_HALT_EN
  logic                       HALTED;
`endif

  // Fetch unit side
  modport master (
    input  EN, MEM_DATA, BR_VALID, BR_TARGET, OUT_READY,
    output MEM_ADDR, OUT_VALID, OPCODE, OPERAND, PC_OUT
`ifdef FETCH_HALT_EN
    , output HALTED
`endif
  );

  // ROM / control / execute side
  modport slave (
    output EN, MEM_DATA, BR_VALID, BR_TARGET, OUT_READY,
    input  MEM_ADDR, OUT_VALID, OPCODE, OPERAND, PC_OUT
`ifdef FETCH_HALT_EN
    , input HALTED
`endif
  );

endinterface

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter register: load has priority over increment, and the
// increment wraps modulo 2^ADDR_W.
module pc_register #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  // Next PC: redirect wins over sequential advance
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC storage with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, synchronous ROM request, instruction register
// and a valid/ready output toward execute. Redirects squash in-flight fetches.
// FETCH_HALT_EN: a handshaken instruction with opcode HALT_OPC parks the FSM
// in S_HALT (HALTED=1) until a redirect or reset.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int OPC_W   = OPC_W_DEF
`ifdef FETCH_HALT_EN
  , parameter logic [OPC_W-1:0] HALT_OPC = OPC_W'(HALT_OPC_DEF)
`endif
) (
  input  logic                 CLK,
  input  logic                 RST,
  instr_fetch_unit_if.master   bus,
  output fetch_state_t         state_dbg
);

  localparam int OPR_W = INSTR_W - OPC_W;

  fetch_state_t       state_d, state_q;
  logic [INSTR_W-1:0] ir_d, ir_q;
  logic [ADDR_W-1:0]  pc_out_d, pc_out_q;
  logic               out_valid_d, out_valid_q;
  logic               halted_d, halted_q;
  logic               pc_load;
  logic               pc_inc;
  logic [ADDR_W-1:0]  pc;

  pc_register #(.ADDR_W(ADDR_W)) u_pc (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (pc_load),
    .load_val (bus.BR_TARGET),
    .inc      (pc_inc),
    .pc       (pc)
  );

  // Next-state and datapath control; a redirect overrides every state
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    pc_out_d    = pc_out_q;
    out_valid_d = out_valid_q;
    halted_d    = halted_q;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    if (bus.BR_VALID) begin
      // Any held word is either consumed this cycle or squashed; both end valid
      pc_load     = 1'b1;
      out_valid_d = 1'b0;
      halted_d    = 1'b0;
      state_d     = bus.EN ? S_REQ : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.EN) state_d = S_REQ;
        end
        S_REQ: begin
          // ROM samples MEM_ADDR (=PC) at this edge
          state_d = S_WAIT;
        end
        S_WAIT: begin
          ir_d        = bus.MEM_DATA;
          pc_out_d    = pc;
          pc_inc      = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_VALID;
        end
        S_VALID: begin
          if (bus.OUT_READY) begin
            out_valid_d = 1'b0;
            state_d     = bus.EN ? S_REQ : S_IDLE;
`ifdef FETCH_HALT_EN
            if (ir_q[INSTR_W-1 -: OPC_W] == HALT_OPC) begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end
`endif
          end
        end
`ifdef FETCH_HALT_EN
        S_HALT: begin
          state_d = S_HALT;
        end
`endif
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      pc_out_q    <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      pc_out_q    <= pc_out_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.MEM_ADDR  = pc;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OPCODE    = ir_q[INSTR_W-1 -: OPC_W];
  assign bus.OPERAND   = ir_q[OPR_W-1:0];
  assign bus.PC_OUT    = pc_out_q;
  assign state_dbg     = state_q;

`ifdef FETCH_HALT_EN
  assign bus.HALTED = halted_q;
`else
  // halted_q is constant 0 without the halt feature; keep it referenced
  logic halted_unused;
  assign halted_unused = halted_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus hand
// sequences for mid-fetch reset and (with FETCH_HALT_EN) halt/resume.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  typedef struct {
    logic         en;
    logic         ready;
    logic         br;
    logic [11:0]  tgt;
    fetch_state_t st;
    logic         vld;
    logic [3:0]   opc;
    logic [3:0]   opr;
    logic [11:0]  pco;
    logic [11:0]  addr;
  } vec_t;

  localparam int NVEC = 33;

  logic         clk;
  logic         rst;
  fetch_state_t state_dbg;
  logic [7:0]   rom [0:4095];
  vec_t         vecs [NVEC];
  int           checks;
  int           errors;

  instr_fetch_unit_if #(.ADDR_W(12), .INSTR_W(8), .OPC_W(4)) bus ();

  instr_fetch_unit dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock and synchronous ROM model (data valid the cycle after the address)
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.MEM_DATA <= rom[bus.MEM_ADDR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic ready, input logic br,
                              input logic [11:0] tgt, input fetch_state_t st,
                              input logic vld, input logic [3:0] opc,
                              input logic [3:0] opr, input logic [11:0] pco,
                              input logic [11:0] addr);
    vec_t v;
    v.en = en; v.ready = ready; v.br = br; v.tgt = tgt; v.st = st;
    v.vld = vld; v.opc = opc; v.opr = opr; v.pco = pco; v.addr = addr;
    return v;
  endfunction

  task automatic drive(input logic en, input logic ready, input logic br, input logic [11:0] tgt);
    bus.EN        = en;
    bus.OUT_READY = ready;
    bus.BR_VALID  = br;
    bus.BR_TARGET = tgt;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[0]     = 8'h3A;
    rom[1]     = 8'h51;
    rom[2]     = 8'h27;
    rom[3]     = 8'hD3;
    rom[5]     = 8'hC4;
    rom[12'h100] = 8'h9B;
    rom[12'hFFF] = 8'h6E;

    // Each row: inputs applied after checking the state seen at this negedge
    vecs[0]  = mk(1, 1, 0, 12'h000, S_IDLE,  0, 4'h0, 4'h0, 12'h000, 12'h000);
    vecs[1]  = mk(1, 1, 0, 12'h000, S_REQ,   0, 4'h0, 4'h0, 12'h000, 12'h000);
    vecs[2]  = mk(1, 1, 0, 12'h000, S_WAIT,  0, 4'h0, 4'h0, 12'h000, 12'h000);
    vecs[3]  = mk(1, 1, 0, 12'h000, S_VALID, 1, 4'h3, 4'hA, 12'h000, 12'h001);
    vecs[4]  = mk(1, 0, 0, 12'h000, S_REQ,   0, 4'h0, 4'h0, 12'h000, 12'h001);
    vecs[5]  = mk(1, 0, 0, 12'h000, S_WAIT,  0, 4'h0, 4'h0, 12'h000, 12'h001);
    vecs[6]  = mk(1, 0, 0, 12'h000, S_VALID, 1, 4'h5, 4'h1, 12'h001, 12'h002);
    vecs[7]  = mk(1, 0, 0, 12'h000, S_VALID, 1, 4'h5, 4'h1, 12'h001, 12'h002);
    vecs[8]  = mk(1, 0, 0, 12'h000, S_VALID, 1, 4'h5, 4'h1, 12'h001, 12'h002);
    vecs[9]  = mk(1, 0, 0, 12'h000, S_VALID, 1, 4'h5, 4'h1, 12'h001, 12'h002);
    vecs[10] = mk(1, 0, 0, 12'h000, S_VALID, 1, 4'h5, 4'h1, 12'h001, 12'h002);
    vecs[11] = mk(1, 1, 0, 12'h000, S_VALID, 1, 4'h5, 4'h1, 12'h001, 12'h002);
    vecs[12] = mk(1, 1, 0, 12'h000, S_REQ,   0, 4'h0, 4'h0, 12'h000, 12'h002);
    vecs[13] = mk(1, 1, 0, 12'h000, S_WAIT,  0, 4'h0, 4'h0, 12'h000, 12'h002);
    vecs[14] = mk(1, 1, 0, 12'h000, S_VALID, 1, 4'h2, 4'h7, 12'h002, 12'h003);
    vecs[15] = mk(1, 1, 0, 12'h000, S_REQ,   0, 4'h0, 4'h0, 12'h000, 12'h003);
    vecs[16] = mk(1, 1, 1, 12'h100, S_WAIT,  0, 4'h0, 4'h0, 12'h000, 12'h003);
    vecs[17] = mk(1, 1, 0, 12'h000, S_REQ,   0, 4'h0, 4'h0, 12'h000, 12'h100);
    vecs[18] = mk(1, 1, 0, 12'h000, S_WAIT,  0, 4'h0, 4'h0, 12'h000, 12'h100);
    vecs[19] = mk(1, 1, 1, 12'hFFF, S_VALID, 1, 4'h9, 4'hB, 12'h100, 12'h101);
    vecs[20] = mk(1, 1, 0, 12'h000, S_REQ,   0, 4'h0, 4'h0, 12'h000, 12'hFFF);
    vecs[21] = mk(1, 1, 0, 12'h000, S_WAIT,  0, 4'h0, 4'h0, 12'h000, 12'hFFF);
    vecs[22] = mk(1, 1, 0, 12'h000, S_VALID, 1, 4'h6, 4'hE, 12'hFFF, 12'h000);
    vecs[23] = mk(1, 1, 0, 12'h000, S_REQ,   0, 4'h0, 4'h0, 12'h000, 12'h000);
    vecs[24] = mk(1, 1, 0, 12'h000, S_WAIT,  0, 4'h0, 4'h0, 12'h000, 12'h000);
    vecs[25] = mk(0, 1, 0, 12'h000, S_VALID, 1, 4'h3, 4'hA, 12'h000, 12'h001);
    vecs[26] = mk(0, 0, 1, 12'h005, S_IDLE,  0, 4'h0, 4'h0, 12'h000, 12'h001);
    vecs[27] = mk(1, 0, 0, 12'h000, S_IDLE,  0, 4'h0, 4'h0, 12'h000, 12'h005);
    vecs[28] = mk(0, 0, 0, 12'h000, S_REQ,   0, 4'h0, 4'h0, 12'h000, 12'h005);
    vecs[29] = mk(0, 0, 0, 12'h000, S_WAIT,  0, 4'h0, 4'h0, 12'h000, 12'h005);
    vecs[30] = mk(0, 0, 0, 12'h000, S_VALID, 1, 4'hC, 4'h4, 12'h005, 12'h006);
    vecs[31] = mk(0, 1, 0, 12'h000, S_VALID, 1, 4'hC, 4'h4, 12'h005, 12'h006);
    vecs[32] = mk(0, 0, 0, 12'h000, S_IDLE,  0, 4'h0, 4'h0, 12'h000, 12'h006);

    // Reset: two cycles low, then release
    rst = 1'b0;
    drive(0, 0, 0, 12'h000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    chk("rst_opcode", 32'(bus.OPCODE), 32'h0);
    chk("rst_operand", 32'(bus.OPERAND), 32'h0);
    chk("rst_pc_out", 32'(bus.PC_OUT), 32'h0);
`ifdef FETCH_HALT_EN
    chk("rst_halted", 32'(bus.HALTED), 32'h0);
`endif

    // Table phase
    for (int i = 0; i < NVEC; i++) begin
      if (i != 0) @(negedge clk);
      chk($sformatf("v%0d_state", i), 32'(state_dbg), 32'(vecs[i].st));
      chk($sformatf("v%0d_valid", i), 32'(bus.OUT_VALID), 32'(vecs[i].vld));
      chk($sformatf("v%0d_mem_addr", i), 32'(bus.MEM_ADDR), 32'(vecs[i].addr));
      if (vecs[i].vld) begin
        chk($sformatf("v%0d_opcode", i), 32'(bus.OPCODE), 32'(vecs[i].opc));
        chk($sformatf("v%0d_operand", i), 32'(bus.OPERAND), 32'(vecs[i].opr));
        chk($sformatf("v%0d_pc_out", i), 32'(bus.PC_OUT), 32'(vecs[i].pco));
      end
      drive(vecs[i].en, vecs[i].ready, vecs[i].br, vecs[i].tgt);
    end

    // Reset asserted while a fetch is in S_WAIT
    @(negedge clk);
    drive(1, 1, 0, 12'h000);
    @(negedge clk);
    chk("mid_rst_req", 32'(state_dbg), 32'(S_REQ));
    @(negedge clk);
    chk("mid_rst_wait", 32'(state_dbg), 32'(S_WAIT));
    rst = 1'b0;
    drive(0, 0, 0, 12'h000);
    @(negedge clk);
    chk("mid_rst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("mid_rst_valid", 32'(bus.OUT_VALID), 32'h0);
    chk("mid_rst_mem_addr", 32'(bus.MEM_ADDR), 32'h0);
    chk("mid_rst_pc_out", 32'(bus.PC_OUT), 32'h0);
    chk("mid_rst_opcode", 32'(bus.OPCODE), 32'h0);
    chk("mid_rst_operand", 32'(bus.OPERAND), 32'h0);
    rst = 1'b1;

`ifdef FETCH_HALT_EN
    begin
      logic found;
      rom[2] = 8'hF0;
      drive(1, 1, 0, 12'h000);
      found = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (bus.OUT_VALID && bus.PC_OUT == 12'h002) begin
          found = 1'b1;
          break;
        end
      end
      chk("halt_word_seen", 32'(found), 32'h1);
      chk("halt_word_opcode", 32'(bus.OPCODE), 32'hF);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk($sformatf("halt_flag_%0d", k), 32'(bus.HALTED), 32'h1);
        chk($sformatf("halt_state_%0d", k), 32'(state_dbg), 32'(S_HALT));
        chk($sformatf("halt_valid_%0d", k), 32'(bus.OUT_VALID), 32'h0);
        chk($sformatf("halt_mem_addr_%0d", k), 32'(bus.MEM_ADDR), 32'h3);
      end
      drive(1, 1, 1, 12'h000);
      @(negedge clk);
      drive(1, 1, 0, 12'h000);
      chk("halt_clear", 32'(bus.HALTED), 32'h0);
      chk("halt_resume_state", 32'(state_dbg), 32'(S_REQ));
      chk("halt_resume_addr", 32'(bus.MEM_ADDR), 32'h0);
      repeat (2) @(negedge clk);
      chk("halt_resume_valid", 32'(bus.OUT_VALID), 32'h1);
      chk("halt_resume_pc_out", 32'(bus.PC_OUT), 32'h0);
      chk("halt_resume_opcode", 32'(bus.OPCODE), 32'h3);
      drive(0, 0, 0, 12'h000);
    end
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
